// File: rtl/ldpc_pkg.sv
// Shared types and helpers for the LDPC check-node datapath.
// LLRs of any supported width are sign-extended to LDPC_MAX_WIDTH before these helpers see them.
package ldpc_pkg;

   localparam int LDPC_MAX_WIDTH = 12;

   typedef enum logic {
      LDPC_MINSUM        = 1'b0,
      LDPC_OFFSET_MINSUM = 1'b1
   } ldpc_mode_e;

   typedef logic signed [LDPC_MAX_WIDTH-1:0] ldpc_llr_t;
   typedef logic [LDPC_MAX_WIDTH-2:0]        ldpc_mag_t;

   function automatic ldpc_mag_t max_mag(input int width);
      return ldpc_mag_t'((1 << (width - 1)) - 1);
   endfunction

   // The most negative code of a width-bit LLR clamps to max_mag(width) instead of wrapping.
   function automatic ldpc_mag_t sat_abs(input ldpc_llr_t llr, input int width);
      logic signed [LDPC_MAX_WIDTH:0] ext;
      logic [LDPC_MAX_WIDTH:0]        mag;
      ext = {llr[LDPC_MAX_WIDTH-1], llr};
      mag = ext[LDPC_MAX_WIDTH] ? -ext : ext;
      if (mag > {2'b00, max_mag(width)}) begin
         mag = {2'b00, max_mag(width)};
      end
      return mag[LDPC_MAX_WIDTH-2:0];
   endfunction

endpackage

// File: rtl/ldpc_check_node_if.sv
// Streaming port bundle of the check node: variable-to-check beats in and check-to-variable beats out.
interface ldpc_check_node_if #(
   parameter int DEGREE = 6,
   parameter int WIDTH  = 8
);
   localparam int IDX_W = $clog2(DEGREE);

   logic [DEGREE*WIDTH-1:0] i_llr;
   logic [DEGREE-1:0]       i_edge_mask;
   logic                    i_mode;
   logic [WIDTH-2:0]        i_offset;
   logic                    i_valid;
   logic                    o_ready;
   logic [DEGREE*WIDTH-1:0] o_llr;
   logic [IDX_W-1:0]        o_min_index;
   logic                    o_parity;
   logic                    o_valid;
   logic                    i_ready;

   modport master (
      output i_llr, i_edge_mask, i_mode, i_offset, i_valid, i_ready,
      input  o_ready, o_llr, o_min_index, o_parity, o_valid
   );

   modport slave (
      input  i_llr, i_edge_mask, i_mode, i_offset, i_valid, i_ready,
      output o_ready, o_llr, o_min_index, o_parity, o_valid
   );

endinterface

// File: rtl/ldpc_two_min_tree.sv
// Finds the smallest and second-smallest of N magnitudes plus the index of the first smallest.
// Strict less-than keeps the lowest index on ties and lets a tied value fall through into min2.
module ldpc_two_min_tree
   import ldpc_pkg::*;
#(
   parameter int  N     = 6,
   parameter int  WIDTH = 8,
   localparam int MAG_W = WIDTH - 1,
   localparam int IDX_W = $clog2(N)
) (
   input  logic [N-1:0][MAG_W-1:0] mag,
   output logic [MAG_W-1:0]        min1,
   output logic [MAG_W-1:0]        min2,
   output logic [IDX_W-1:0]        idx1
);

   localparam logic [MAG_W-1:0] MAX_MAG = MAG_W'(max_mag(WIDTH));

   always_comb begin
      min1 = mag[0];
      min2 = MAX_MAG;
      idx1 = '0;
      for (int k = 1; k < N; k++) begin
         if (mag[k] < min1) begin
            min2 = min1;
            min1 = mag[k];
            idx1 = IDX_W'(k);
         end else if (mag[k] < min2) begin
            min2 = mag[k];
         end
      end
   end

endmodule

// File: rtl/ldpc_check_node.sv
// Four-stage min-sum check node: magnitude/sign split, two-minimum search, optional offset, output build.
// A single global enable stalls every stage together whenever the output beat is held by the consumer.
module ldpc_check_node
   import ldpc_pkg::*;
#(
   parameter int  DEGREE = 6,
   parameter int  WIDTH  = 8,
   localparam int IDX_W  = $clog2(DEGREE)
) (
   input logic               i_clock,
   input logic               i_reset,
   ldpc_check_node_if.slave  bus
);

   localparam int               MAG_W   = WIDTH - 1;
   localparam logic [MAG_W-1:0] MAX_MAG = MAG_W'(max_mag(WIDTH));

   logic en;

   logic signed [WIDTH-1:0]         llr_in [DEGREE];
   logic [DEGREE-1:0][MAG_W-1:0]    mag_in;
   logic [DEGREE-1:0]               sign_in;

   logic                            s1_valid;
   logic [DEGREE-1:0][MAG_W-1:0]    s1_mag;
   logic [DEGREE-1:0]               s1_sign;
   logic [DEGREE-1:0]               s1_mask;
   ldpc_mode_e                      s1_mode;
   logic [MAG_W-1:0]                s1_offset;

   logic [MAG_W-1:0]                tree_min1;
   logic [MAG_W-1:0]                tree_min2;
   logic [IDX_W-1:0]                tree_idx1;

   logic                            s2_valid;
   logic [MAG_W-1:0]                s2_min1;
   logic [MAG_W-1:0]                s2_min2;
   logic [IDX_W-1:0]                s2_idx1;
   logic                            s2_parity;
   logic [DEGREE-1:0]               s2_sign;
   logic [DEGREE-1:0]               s2_mask;
   ldpc_mode_e                      s2_mode;
   logic [MAG_W-1:0]                s2_offset;

   logic                            s3_valid;
   logic [MAG_W-1:0]                s3_min1;
   logic [MAG_W-1:0]                s3_min2;
   logic [IDX_W-1:0]                s3_idx1;
   logic                            s3_parity;
   logic [DEGREE-1:0]               s3_sign;
   logic [DEGREE-1:0]               s3_mask;

   logic [DEGREE-1:0][MAG_W-1:0]    sel_mag;
   logic [DEGREE*WIDTH-1:0]         out_llr;

   function automatic logic [MAG_W-1:0] apply_offset(input logic [MAG_W-1:0] m,
                                                     input logic [MAG_W-1:0] off,
                                                     input ldpc_mode_e       mode);
      if (mode == LDPC_MINSUM) return m;
      return (m > off) ? (m - off) : '0;
   endfunction

   assign en          = bus.i_ready | ~bus.o_valid;
   assign bus.o_ready = en;

   // Masked edges look like the largest magnitude with a positive sign, so they never win a minimum or flip parity.
   always_comb begin
      for (int k = 0; k < DEGREE; k++) begin
         llr_in[k]  = bus.i_llr[k*WIDTH +: WIDTH];
         mag_in[k]  = MAX_MAG;
         sign_in[k] = 1'b0;
         if (bus.i_edge_mask[k]) begin
            mag_in[k]  = MAG_W'(sat_abs(ldpc_llr_t'(llr_in[k]), WIDTH));
            sign_in[k] = llr_in[k][WIDTH-1];
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         s1_valid <= 1'b0;
      end else if (en) begin
         s1_valid  <= bus.i_valid;
         s1_mag    <= mag_in;
         s1_sign   <= sign_in;
         s1_mask   <= bus.i_edge_mask;
         s1_mode   <= ldpc_mode_e'(bus.i_mode);
         s1_offset <= bus.i_offset;
      end
   end

   ldpc_two_min_tree #(
      .N     (DEGREE),
      .WIDTH (WIDTH)
   ) u_two_min (
      .mag  (s1_mag),
      .min1 (tree_min1),
      .min2 (tree_min2),
      .idx1 (tree_idx1)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         s2_valid <= 1'b0;
      end else if (en) begin
         s2_valid  <= s1_valid;
         s2_min1   <= tree_min1;
         s2_min2   <= tree_min2;
         s2_idx1   <= tree_idx1;
         s2_parity <= ^s1_sign;
         s2_sign   <= s1_sign;
         s2_mask   <= s1_mask;
         s2_mode   <= s1_mode;
         s2_offset <= s1_offset;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         s3_valid <= 1'b0;
      end else if (en) begin
         s3_valid  <= s2_valid;
         s3_min1   <= apply_offset(s2_min1, s2_offset, s2_mode);
         s3_min2   <= apply_offset(s2_min2, s2_offset, s2_mode);
         s3_idx1   <= s2_idx1;
         s3_parity <= s2_parity;
         s3_sign   <= s2_sign;
         s3_mask   <= s2_mask;
      end
   end

   // Each edge receives the extrinsic minimum and the parity of the other signs.
   always_comb begin
      out_llr = '0;
      for (int k = 0; k < DEGREE; k++) begin
         sel_mag[k] = (IDX_W'(k) == s3_idx1) ? s3_min2 : s3_min1;
         if (s3_mask[k]) begin
            out_llr[k*WIDTH +: WIDTH] = (s3_parity ^ s3_sign[k]) ? -{1'b0, sel_mag[k]}
                                                                 :  {1'b0, sel_mag[k]};
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         bus.o_valid     <= 1'b0;
         bus.o_llr       <= '0;
         bus.o_min_index <= '0;
         bus.o_parity    <= 1'b0;
      end else if (en) begin
         bus.o_valid     <= s3_valid;
         bus.o_llr       <= out_llr;
         bus.o_min_index <= s3_idx1;
         bus.o_parity    <= s3_parity;
      end
   end

endmodule

// File: tb/tb_ldpc_check_node.sv
// Directed and backpressured stimulus for ldpc_check_node, checked against hand values and an extrinsic-min model.
module tb_ldpc_check_node;
   import ldpc_pkg::*;

   localparam int DEGREE = 6;
   localparam int WIDTH  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ldpc_check_node_if #(.DEGREE(DEGREE), .WIDTH(WIDTH)) bus ();

   ldpc_check_node #(.DEGREE(DEGREE), .WIDTH(WIDTH)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [47:0] pack6(input int a0, input int a1, input int a2,
                                         input int a3, input int a4, input int a5);
      return {8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
   endfunction

   // Reference: each edge takes the min magnitude and sign product over the other active edges.
   task automatic modelBeat(input logic [47:0] llr, input logic [5:0] mask, input logic mode,
                            input logic [6:0] offset, output logic [47:0] exp_llr,
                            output logic [2:0] exp_idx, output logic exp_par);
      int   mag [6];
      bit   sgn [6];
      int   best;
      int   m;
      int   sv;
      bit   s;
      logic [7:0] v8;
      exp_llr = '0;
      exp_idx = '0;
      exp_par = 1'b0;
      best    = 1000;
      for (int j = 0; j < 6; j++) begin
         v8     = llr[j*8 +: 8];
         sv     = int'($signed(v8));
         mag[j] = (sv < 0) ? -sv : sv;
         if (mag[j] > 127) mag[j] = 127;
         sgn[j] = v8[7];
         if (!mask[j]) begin
            mag[j] = 127;
            sgn[j] = 1'b0;
         end
         if (mag[j] < best) begin
            best    = mag[j];
            exp_idx = 3'(j);
         end
         if (mask[j]) exp_par ^= sgn[j];
      end
      for (int k = 0; k < 6; k++) begin
         if (mask[k]) begin
            m = 127;
            s = 1'b0;
            for (int j = 0; j < 6; j++) begin
               if (j != k && mask[j]) begin
                  if (mag[j] < m) m = mag[j];
                  s ^= sgn[j];
               end
            end
            if (mode) m = (m > int'(offset)) ? m - int'(offset) : 0;
            exp_llr[k*8 +: 8] = s ? 8'(-m) : 8'(m);
         end
      end
   endtask

   // Pipeline must be empty; called #1 after a rising edge.
   task automatic applyStimulus(input string tag, input logic [47:0] llr, input logic [5:0] mask,
                                input logic mode, input logic [6:0] offset, input logic [47:0] exp_llr,
                                input logic [2:0] exp_idx, input logic exp_par);
      int n;
      bus.i_llr       = llr;
      bus.i_edge_mask = mask;
      bus.i_mode      = mode;
      bus.i_offset    = offset;
      bus.i_ready     = 1'b1;
      bus.i_valid     = 1'b1;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      n = 1;
      while (!bus.o_valid && n < 12) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput({tag, "_latency"}, 64'(n), 64'd4);
      checkOutput({tag, "_llr"}, 64'(bus.o_llr), 64'(exp_llr));
      checkOutput({tag, "_idx"}, 64'(bus.o_min_index), 64'(exp_idx));
      checkOutput({tag, "_parity"}, 64'(bus.o_parity), 64'(exp_par));
      @(posedge clk);
      #1;
   endtask

   logic [47:0] b_llr  [10];
   logic [5:0]  b_mask [10];
   logic        b_mode [10];
   logic [6:0]  b_off  [10];
   logic [47:0] e_llr  [10];
   logic [2:0]  e_idx  [10];
   logic        e_par  [10];

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          sent;
      int          recv;
      int          cyc;
      logic [3:0]  pv;
      logic        exp_en;
      logic        hold;
      logic [47:0] held_llr;
      logic [63:0] r;

      bus.i_llr       = '0;
      bus.i_edge_mask = '0;
      bus.i_mode      = 1'b0;
      bus.i_offset    = '0;
      bus.i_valid     = 1'b0;
      bus.i_ready     = 1'b1;
      rst             = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset_valid", 64'(bus.o_valid), 64'd0);
      checkOutput("reset_llr", 64'(bus.o_llr), 64'd0);
      checkOutput("reset_idx", 64'(bus.o_min_index), 64'd0);
      checkOutput("reset_parity", 64'(bus.o_parity), 64'd0);
      checkOutput("reset_ready", 64'(bus.o_ready), 64'd1);

      applyStimulus("plain", pack6(10, -3, 7, 20, -5, 4), 6'h3F, 1'b0, 7'd0,
                    pack6(3, -4, 3, 3, -3, 3), 3'd1, 1'b0);
      applyStimulus("offset2", pack6(10, -3, 7, 20, -5, 4), 6'h3F, 1'b1, 7'd2,
                    pack6(1, -2, 1, 1, -1, 1), 3'd1, 1'b0);
      applyStimulus("offset5", pack6(10, -3, 7, 20, -5, 4), 6'h3F, 1'b1, 7'd5,
                    48'd0, 3'd1, 1'b0);
      applyStimulus("mask_sat", pack6(-128, 9, 1, -2, 3, -4), 6'b000011, 1'b0, 7'd0,
                    pack6(9, -127, 0, 0, 0, 0), 3'd1, 1'b1);
      applyStimulus("tie", pack6(5, 5, 5, 5, 5, 5), 6'h3F, 1'b0, 7'd0,
                    pack6(5, 5, 5, 5, 5, 5), 3'd0, 1'b0);
      applyStimulus("no_edges", pack6(-1, -2, 3, -4, 5, -6), 6'h00, 1'b0, 7'd0,
                    48'd0, 3'd0, 1'b0);
      applyStimulus("plain_offset_mode0", pack6(10, -3, 7, 20, -5, 4), 6'h3F, 1'b0, 7'd2,
                    pack6(3, -4, 3, 3, -3, 3), 3'd1, 1'b0);

      for (int i = 0; i < 10; i++) begin
         r         = {$urandom, $urandom};
         b_llr[i]  = r[47:0];
         b_mask[i] = 6'($urandom_range(1, 63));
         b_mode[i] = 1'($urandom_range(0, 1));
         b_off[i]  = 7'($urandom_range(0, 20));
         modelBeat(b_llr[i], b_mask[i], b_mode[i], b_off[i], e_llr[i], e_idx[i], e_par[i]);
      end

      sent = 0;
      recv = 0;
      cyc  = 0;
      pv   = '0;
      while (recv < 10 && cyc < 400) begin
         bus.i_ready = 1'($urandom_range(0, 1));
         bus.i_valid = (sent < 10);
         if (sent < 10) begin
            bus.i_llr       = b_llr[sent];
            bus.i_edge_mask = b_mask[sent];
            bus.i_mode      = b_mode[sent];
            bus.i_offset    = b_off[sent];
         end
         #1;
         exp_en = bus.i_ready | ~pv[3];
         checkOutput("bp_ready", 64'(bus.o_ready), 64'(exp_en));
         checkOutput("bp_valid", 64'(bus.o_valid), 64'(pv[3]));
         if (bus.o_valid && bus.i_ready && recv < 10) begin
            checkOutput("bp_llr", 64'(bus.o_llr), 64'(e_llr[recv]));
            checkOutput("bp_idx", 64'(bus.o_min_index), 64'(e_idx[recv]));
            checkOutput("bp_parity", 64'(bus.o_parity), 64'(e_par[recv]));
            recv++;
         end
         hold     = bus.o_valid && !bus.i_ready;
         held_llr = bus.o_llr;
         @(posedge clk);
         if (exp_en) begin
            pv = {pv[2:0], bus.i_valid};
            if (bus.i_valid) sent++;
         end
         #1;
         if (hold) checkOutput("bp_hold", 64'(bus.o_llr), 64'(held_llr));
         cyc++;
      end
      checkOutput("bp_count", 64'(recv), 64'd10);
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("bp_drained", 64'(bus.o_valid), 64'd0);

      bus.i_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.i_llr       = b_llr[i];
         bus.i_edge_mask = b_mask[i];
         bus.i_mode      = b_mode[i];
         bus.i_offset    = b_off[i];
         bus.i_valid     = 1'b1;
         @(posedge clk);
         #1;
      end
      bus.i_valid = 1'b0;
      rst         = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("midrst_valid", 64'(bus.o_valid), 64'd0);
      checkOutput("midrst_llr", 64'(bus.o_llr), 64'd0);
      applyStimulus("post_reset", pack6(10, -3, 7, 20, -5, 4), 6'h3F, 1'b0, 7'd0,
                    pack6(3, -4, 3, 3, -3, 3), 3'd1, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("post_reset_empty", 64'(bus.o_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
